req_ack_done_resp: RTL and testbench
====================================

# req_ack_done_resp

Responder end of the four-phase req/ack/done handshake used across the assertion-example blocks. It waits for `req`, raises `ack` after a programmable delay, raises `done` after a second programmable delay, then releases both once `req` drops. It also reports early requester aborts and counts completed transactions. It serves as the synthesizable counterpart that drives `ack` and `done` against requester-side DUTs and their liveness (eventually) properties.

## Interface
- `CNT_W`, default 4: width of the delay inputs and the internal down-counter.
- `TXN_W`, default 8: width of the completed-transaction counter.
- `clk`, in, 1: single clock; all logic on posedge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `req`, in, 1: request from the initiator, level; held high until `done` is seen.
- `ack_dly`, in, `CNT_W`: extra cycles before `ack`; sampled only on request accept.
- `done_dly`, in, `CNT_W`: extra cycles from `ack` to `done`; sampled only on request accept.
- `ack`, out, 1: acknowledge, level, registered.
- `done`, out, 1: completion, level, registered.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `abort`, out, 1: one-cycle pulse when `req` drops before `done`.
- `txn_cnt`, out, `TXN_W`: count of completed handshakes; wraps modulo 2^`TXN_W`.

## Operation
- States: IDLE, WAIT_ACK, WAIT_DONE, DONE.
- IDLE, `req`=1 at edge e0:
  - latch `ack_dly` and `done_dly` into shadow registers;
  - load `cnt` ← `ack_dly`;
  - go to WAIT_ACK.
  - Later changes on the delay inputs are ignored until the next accept.
- WAIT_ACK:
  - `cnt`≠0: decrement.
  - `cnt`=0: `ack`←1, `cnt`←latched `done_dly`, go to WAIT_DONE.
- WAIT_DONE:
  - `cnt`≠0: decrement.
  - `cnt`=0: `done`←1, go to DONE.
- DONE: `req` sampled 0 → `ack`←0, `done`←0, `txn_cnt`←`txn_cnt`+1, go to IDLE.
- Abort: `req` sampled 0 in WAIT_ACK or WAIT_DONE:
  - `ack`←0 and `abort`←1 for one cycle;
  - go to IDLE;
  - `txn_cnt` unchanged.
  - The abort check takes priority over the counter-expiry transition in the same cycle.
- `busy` is combinational from the state.

## Timing
- Reset (`rst_n`=0 at an edge) sets state IDLE and `ack`=`done`=`abort`=0, `txn_cnt`=0, `cnt`=0. This applies mid-transaction too: the outputs drop at that edge, with no abort pulse.
- With `req` first sampled high at edge e0:
  - `ack` is set at edge e0+1+`ack_dly`;
  - `done` is set at edge e0+2+`ack_dly`+`done_dly`.
- Zero delays: `ack` is set at e0+1 and `done` at e0+2.
- Release: `req` first sampled low in DONE at edge e1 → `ack`/`done` clear and `txn_cnt` increments at e1.
- Back-to-back: `req` high again at e1+1 is accepted in IDLE at e1+1; there are no dead cycles.
- Maximum handshake latency to `done` is 2+2·(2^`CNT_W`−1) cycles.
- `txn_cnt` wraps from all-ones to 0 with no flag.

## Structure
- Package `req_resp_pkg` holds:
  - the `resp_state_e` enum typedef (IDLE, WAIT_ACK, WAIT_DONE, DONE);
  - default localparams for `CNT_W`/`TXN_W`.
- One sub-module, `resp_dly_cnt`: a loadable `CNT_W` down-counter with a load, a decrement enable and a combinational `zero` output.
- The FSM, the output registers and `txn_cnt` live in the top module.

## Test plan
- Nominal handshake:
  - stimulus: `ack_dly`=3, `done_dly`=1, `req` rises at e0;
  - response: `ack` at e0+4, `done` at e0+6;
  - then `req` low at e0+8: `ack`/`done` low at e0+8 and `txn_cnt`=1.
- Zero delays:
  - stimulus: `ack_dly`=0, `done_dly`=0, `req` at e0;
  - response: `ack` at e0+1, `done` at e0+2, `busy` from e0 onward.
- Early abort:
  - stimulus: `ack_dly`=5, `req` dropped at e0+3;
  - response: `abort`=1 for exactly one cycle, `ack` never rises, `txn_cnt` unchanged, state IDLE.
- Delay-input change mid-transaction:
  - stimulus: `ack_dly`=2 at accept, changed to 9 at e0+1;
  - response: `ack` still at e0+3.
- Reset mid-transaction:
  - stimulus: `rst_n`=0 while in WAIT_DONE with `ack`=1;
  - response: all outputs 0 at that edge, `txn_cnt`=0, no `abort`.
- Wrap and back-to-back:
  - stimulus: `TXN_W`=2, five consecutive zero-delay handshakes with `req` re-raised one cycle after release;
  - response: `txn_cnt` sequence 1,2,3,0,1 and no idle gap between handshakes.

Source files
------------

// File: rtl/req_resp_pkg.sv
// Shared types and defaults for the req/ack/done responder.
package req_resp_pkg;

    localparam int DEF_CNT_W = 4;
    localparam int DEF_TXN_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2,
        DONE      = 2'd3
    } resp_state_e;

endpackage

// File: rtl/resp_dly_cnt.sv
// Loadable down-counter used to time the ack and done delays.
module resp_dly_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/req_ack_done_resp.sv
// Responder side of the four-phase req/ack/done handshake with programmable
// ack and done delays, abort reporting and a completed-transaction counter.
module req_ack_done_resp
    import req_resp_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int TXN_W = DEF_TXN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [CNT_W-1:0] ack_dly,
    input  logic [CNT_W-1:0] done_dly,
    output logic             ack,
    output logic             done,
    output logic             busy,
    output logic             abort,
    output logic [TXN_W-1:0] txn_cnt
);

    resp_state_e      state;
    logic [CNT_W-1:0] done_dly_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic             waiting;

    // ack_dly goes straight into the counter on accept, so only done_dly
    // needs a shadow copy to survive until the ack phase ends.
    assign waiting      = (state == WAIT_ACK) || (state == WAIT_DONE);
    assign cnt_load     = ((state == IDLE) && req) ||
                          ((state == WAIT_ACK) && req && cnt_zero);
    assign cnt_load_val = (state == IDLE) ? ack_dly : done_dly_q;
    assign cnt_dec      = waiting && req && !cnt_zero;
    assign busy         = (state != IDLE);

    resp_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            done_dly_q <= '0;
            ack        <= 1'b0;
            done       <= 1'b0;
            abort      <= 1'b0;
            txn_cnt    <= '0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        done_dly_q <= done_dly;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A dropped req wins over counter expiry in the same cycle.
                    if (!req) begin
                        ack   <= 1'b0;
                        abort <= 1'b1;
                        state <= IDLE;
                    end else if (cnt_zero) begin
                        ack   <= 1'b1;
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!req) begin
                        ack   <= 1'b0;
                        done  <= 1'b0;
                        abort <= 1'b1;
                        state <= IDLE;
                    end else if (cnt_zero) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!req) begin
                        ack     <= 1'b0;
                        done    <= 1'b0;
                        txn_cnt <= txn_cnt + 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_ack_done_resp.sv
// Randomized and directed bench for req_ack_done_resp against a
// time-since-accept reference model.
module tb_req_ack_done_resp;

    localparam int CNT_W = 4;
    localparam int TXN_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic [CNT_W-1:0] ack_dly = '0;
    logic [CNT_W-1:0] done_dly = '0;
    logic             ack, done, busy, abort;
    logic [TXN_W-1:0] txn_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: transaction timing measured in edges since accept
    bit m_act;
    int m_t, m_a, m_d, m_txn;
    bit e_ack, e_done, e_abort;

    req_ack_done_resp #(.CNT_W(CNT_W), .TXN_W(TXN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ack_dly  (ack_dly),
        .done_dly (done_dly),
        .ack      (ack),
        .done     (done),
        .busy     (busy),
        .abort    (abort),
        .txn_cnt  (txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge, update the model from the inputs seen at that edge,
    // and compare every output.
    task automatic step();
        @(posedge clk);
        #1;
        e_abort = 1'b0;
        if (!rst_n) begin
            m_act = 1'b0; m_txn = 0; e_ack = 1'b0; e_done = 1'b0;
        end else if (!m_act) begin
            if (req) begin
                m_act = 1'b1; m_t = 0; m_a = int'(ack_dly); m_d = int'(done_dly);
            end
            e_ack = 1'b0; e_done = 1'b0;
        end else begin
            m_t++;
            if (!req) begin
                if (m_t - 1 >= m_a + m_d + 2) m_txn = (m_txn + 1) % (1 << TXN_W);
                else e_abort = 1'b1;
                m_act = 1'b0; e_ack = 1'b0; e_done = 1'b0;
            end else begin
                e_ack  = (m_t >= m_a + 1);
                e_done = (m_t >= m_a + m_d + 2);
            end
        end
        check("ack", 32'(ack), 32'(e_ack));
        check("done", 32'(done), 32'(e_done));
        check("busy", 32'(busy), 32'(m_act));
        check("abort", 32'(abort), 32'(e_abort));
        check("txn_cnt", 32'(txn_cnt), 32'(m_txn));
    endtask

    initial begin
        int seq [5] = '{1, 2, 3, 0, 1};
        int hold, gap;

        // reset
        rst_n = 1'b0;
        step(); step();
        check("rst_txn", 32'(txn_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        // nominal: ack at e0+4, done at e0+6, release at e0+8
        ack_dly = 4'd3; done_dly = 4'd1; req = 1'b1;
        step();
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 4) check("nom_ack_e4", 32'(ack), 32'd1);
            if (i == 5) check("nom_done_e5", 32'(done), 32'd0);
            if (i == 6) check("nom_done_e6", 32'(done), 32'd1);
        end
        req = 1'b0;
        step();
        check("nom_release", 32'({ack, done}), 32'd0);
        check("nom_txn", 32'(txn_cnt), 32'd1);

        // zero delays
        ack_dly = 4'd0; done_dly = 4'd0; req = 1'b1;
        step();
        check("zero_busy_e0", 32'(busy), 32'd1);
        step();
        check("zero_ack_e1", 32'(ack), 32'd1);
        step();
        check("zero_done_e2", 32'(done), 32'd1);
        step();
        req = 1'b0;
        step();

        // early abort
        ack_dly = 4'd5; done_dly = 4'd2; req = 1'b1;
        step(); step(); step();
        req = 1'b0;
        step();
        check("abort_pulse", 32'(abort), 32'd1);
        check("abort_no_ack", 32'(ack), 32'd0);
        step();
        check("abort_clear", 32'(abort), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_txn", 32'(txn_cnt), 32'd2);

        // delay input change after accept is ignored
        ack_dly = 4'd2; done_dly = 4'd0; req = 1'b1;
        step();
        ack_dly = 4'd9;
        step(); step();
        check("midchg_no_ack_e2", 32'(ack), 32'd0);
        step();
        check("midchg_ack_e3", 32'(ack), 32'd1);
        step(); step();
        req = 1'b0;
        step();

        // reset while in WAIT_DONE with ack high
        ack_dly = 4'd1; done_dly = 4'd4; req = 1'b1;
        step(); step(); step(); step();
        check("rstmid_ack_pre", 32'(ack), 32'd1);
        rst_n = 1'b0;
        step();
        check("rstmid_outs", 32'({ack, done, abort, busy}), 32'd0);
        check("rstmid_txn", 32'(txn_cnt), 32'd0);
        rst_n = 1'b1; req = 1'b0;
        step();
        check("rstmid_no_abort", 32'(abort), 32'd0);

        // wrap and back-to-back with zero delays
        ack_dly = 4'd0; done_dly = 4'd0;
        for (int k = 0; k < 5; k++) begin
            req = 1'b1;
            step();
            check("b2b_accept", 32'(busy), 32'd1);
            step(); step();
            req = 1'b0;
            step();
            check("b2b_txn", 32'(txn_cnt), 32'(seq[k]));
        end

        // randomized requester, including aborts and noisy delay inputs
        for (int n = 0; n < 150; n++) begin
            ack_dly  = CNT_W'($urandom_range(0, 15));
            done_dly = CNT_W'($urandom_range(0, 15));
            req = 1'b1;
            hold = $urandom_range(1, 40);
            for (int h = 0; h < hold; h++) begin
                step();
                ack_dly  = CNT_W'($urandom);
                done_dly = CNT_W'($urandom);
            end
            req = 1'b0;
            step();
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
